skew_buffer: RTL

Parametrised, diagonally skewing row buffer feeding the systolic array edge. A write places lane i of the input word into row (A+i) mod DEPTH, building the staggered wavefront the PE array needs; a straight mode writes all lanes to one row. Reads are autonomous: a START command streams COUNT consecutive rows out over a valid/ready handshake, wrapping at DEPTH. This replaces the fixed 16×8-bit, 32-row buffer with single-cycle reads.

---
 rtl/skew_buffer_pkg.sv | 18 +
 rtl/skew_buffer_mem.sv | 41 ++++
 rtl/skew_buffer.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/skew_buffer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | skew_buffer_pkg : shared types and constants for the skew buffer     |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
package skew_buffer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FIN    = 2'd2
  } state_t;

  localparam logic MODE_STRAIGHT = 1'b0;
  localparam logic MODE_SKEW     = 1'b1;

endpackage : skew_buffer_pkg
`default_nettype wire

// File: rtl/skew_buffer_mem.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | skew_buffer_mem : DEPTH x LANES storage, one write address per lane, |
// | asynchronous read of a full row. Revision 1.0                        |
// +----------------------------------------------------------------------+
module skew_buffer_mem
  import skew_buffer_pkg::*;
#(
  parameter int LANES  = 16,
  parameter int ELEM_W = 8,
  parameter int DEPTH  = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [LANES-1:0]        i_we,
  input  logic [LANES*AW-1:0]     i_waddr,
  input  logic [LANES*ELEM_W-1:0] i_wdata,
  input  logic [AW-1:0]           i_raddr,
  output logic [LANES*ELEM_W-1:0] o_rdata
);

  // Each lane is an independent column so a skewed write can hit a different row per lane.
  for (genvar gl = 0; gl < LANES; gl++) begin : g_lane
    logic [ELEM_W-1:0] r_mem [DEPTH];

    always_ff @(posedge CLK) begin
      if (RESET) begin
        for (int r = 0; r < DEPTH; r++) begin
          r_mem[r] <= '0;
        end
      end else if (i_we[gl]) begin
        r_mem[i_waddr[gl*AW +: AW]] <= i_wdata[gl*ELEM_W +: ELEM_W];
      end
    end

    assign o_rdata[gl*ELEM_W +: ELEM_W] = r_mem[i_raddr];
  end

endmodule : skew_buffer_mem
`default_nettype wire

// File: rtl/skew_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | skew_buffer : diagonally skewing row buffer with autonomous streamed |
// | reads over valid/ready. Revision 1.0                                  |
// +----------------------------------------------------------------------+
module skew_buffer
  import skew_buffer_pkg::*;
#(
  parameter int LANES  = 16,
  parameter int ELEM_W = 8,
  parameter int DEPTH  = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    RETN,
  input  logic                    WEN,
  input  logic                    MODE,
  input  logic [AW-1:0]           A,
  input  logic [LANES*ELEM_W-1:0] D,
  input  logic                    START,
  input  logic [AW-1:0]           RA,
  input  logic [AW:0]             COUNT,
  output logic [LANES*ELEM_W-1:0] Q,
  output logic                    QVALID,
  input  logic                    QREADY,
  output logic                    BUSY,
  output logic                    DONE,
  output logic                    ERR
);

  localparam int W = LANES * ELEM_W;

  state_t              r_state;
  state_t              w_next_state;
  logic [AW-1:0]       r_ptr;
  logic [AW:0]         r_rem;
  logic [W-1:0]        r_q;
  logic                r_qvalid;
  logic                r_busy;
  logic                r_err;
  logic [W-1:0]        w_rdata;
  logic [LANES-1:0]    w_we;
  logic [LANES*AW-1:0] w_waddr;
  logic                w_start;
  logic                w_load;
  logic                w_finish;
  logic                w_err_set;

  assign w_we = {LANES{~WEN & RETN}};

  for (genvar gi = 0; gi < LANES; gi++) begin : g_waddr
    localparam logic [AW-1:0] c_off = AW'(gi);
    assign w_waddr[gi*AW +: AW] = (MODE == MODE_SKEW) ? (A + c_off) : A;
  end

  skew_buffer_mem #(
    .LANES  (LANES),
    .ELEM_W (ELEM_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .CLK     (CLK),
    .RESET   (RESET),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (D),
    .i_raddr (r_ptr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // With RETN low every strobe stays at its default, which freezes the whole block.
  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_load       = 1'b0;
    w_finish     = 1'b0;
    w_err_set    = 1'b0;
    if (RETN) begin
      case (r_state)
        ST_IDLE: begin
          if (START) begin
            w_start      = 1'b1;
            w_next_state = (COUNT == '0) ? ST_FIN : ST_STREAM;
          end
        end
        ST_STREAM: begin
          w_err_set = START;
          if (!r_qvalid || QREADY) begin
            if (r_rem != '0) begin
              w_load = 1'b1;
            end else begin
              w_finish     = 1'b1;
              w_next_state = ST_FIN;
            end
          end
        end
        ST_FIN: begin
          w_err_set    = START;
          w_next_state = ST_IDLE;
        end
        default: w_next_state = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_ptr    <= '0;
      r_rem    <= '0;
      r_q      <= '0;
      r_qvalid <= 1'b0;
      r_busy   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (w_err_set) begin
        r_err <= 1'b1;
      end
      if (w_start) begin
        r_ptr <= RA;
        r_rem <= COUNT;
      end
      // The output register captures the row, so later writes cannot disturb a held beat.
      if (w_load) begin
        r_q      <= w_rdata;
        r_qvalid <= 1'b1;
        r_busy   <= 1'b1;
        r_ptr    <= r_ptr + 1'b1;
        r_rem    <= r_rem - 1'b1;
      end
      if (w_finish) begin
        r_q      <= '0;
        r_qvalid <= 1'b0;
        r_busy   <= 1'b0;
      end
    end
  end

  assign Q      = r_qvalid ? r_q : '0;
  assign QVALID = r_qvalid;
  assign BUSY   = r_busy;
  assign DONE   = (r_state == ST_FIN);
  assign ERR    = r_err;

endmodule : skew_buffer
`default_nettype wire
